// File: rtl/sram_serial_tx_if.sv
// Signal bundle between the AVR/SRAM side and the serial read-back engine.
// The master modport is the environment (AVR control pins + SRAM data bus),
// the slave modport is the sram_serial_tx engine itself.
interface sram_serial_tx_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
);
    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              rd_start;
    logic [DATA_W-1:0] sram_data;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              avr_so;
    logic              so_valid;
    logic              busy;
    logic              done;

    modport master (
        output addr_load, addr_in, rd_start, sram_data,
        input  sram_addr, sram_ce_n, sram_oe_n, avr_so, so_valid, busy, done
    );

    modport slave (
        input  addr_load, addr_in, rd_start, sram_data,
        output sram_addr, sram_ce_n, sram_oe_n, avr_so, so_valid, busy, done
    );
endinterface

// File: rtl/sram_serial_tx.sv
// Read-back path of the AVR<->CPLD serial link.
// On rd_start, strobes the SRAM for WAIT_CYC cycles at the current address,
// captures the byte, shifts it out MSB-first on avr_so (one bit per clock),
// pulses done, then post-increments the address (modulo 2^ADDR_W).
// Optional feature macro SO_PARITY_EN: appends an even-parity bit (XOR of the
// captured byte) after the data bits, lengthening the shift phase by one cycle.
module sram_serial_tx #(
    parameter int ADDR_W   = 21,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input logic             avr_clk,
    input logic             reset,
    sram_serial_tx_if.slave bus
);

`ifdef SO_PARITY_EN
    localparam int SH_W = DATA_W + 1;
`else
    localparam int SH_W = DATA_W;
`endif
    localparam int CNT_MAX = (WAIT_CYC > SH_W) ? (WAIT_CYC - 1) : (SH_W - 1);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [SH_W-1:0]   shreg;
    logic [SH_W-1:0]   cap_word;
    logic [ADDR_W-1:0] addr;
    logic              capture;
    logic              shift_en;
    logic              load_en;
    logic              incr_en;

`ifdef SO_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Parity rides in the LSB so it leaves last, right after the data bits
    assign cap_word = {bus.sram_data, even_parity(bus.sram_data)};
`else
    assign cap_word = bus.sram_data;
`endif

    // State register and per-phase down counter
    always_ff @(posedge avr_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; also decides when the datapath captures, shifts, loads or increments
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        incr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A simultaneous load lands on the same edge, so the read uses the new address
                load_en = bus.addr_load;
                if (bus.rd_start) begin
                    state_next = ST_ACCESS;
                    cnt_next   = CNT_W'(WAIT_CYC - 1);
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_SHIFT;
                    cnt_next   = CNT_W'(SH_W - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                incr_en    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register: parallel capture at the end of ACCESS, then MSB-first shift with zero fill
    always_ff @(posedge avr_clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (capture) begin
            shreg <= cap_word;
        end else if (shift_en) begin
            shreg <= {shreg[SH_W-2:0], 1'b0};
        end
    end

    // Address register: parallel load while idle, post-increment leaving DONE (wraps silently)
    always_ff @(posedge avr_clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (load_en) begin
            addr <= bus.addr_in;
        end else if (incr_en) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately
    assign bus.sram_addr = addr;
    assign bus.sram_ce_n = (state != ST_ACCESS);
    assign bus.sram_oe_n = (state != ST_ACCESS);
    assign bus.avr_so    = (state == ST_SHIFT) ? shreg[SH_W-1] : 1'b1;
    assign bus.so_valid  = (state == ST_SHIFT);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_sram_serial_tx.sv
// Self-checking bench for sram_serial_tx (also builds with SO_PARITY_EN defined).
// The reference predicts, per transaction, a cycle-indexed trace of strobes,
// serial bits, valid, busy and done from the read byte and the timing rules,
// and tracks the address register as a plain counter.
`timescale 1ns/1ps
module tb_sram_serial_tx;
    localparam int ADDR_W   = 21;
    localparam int DATA_W   = 8;
    localparam int WAIT_CYC = 2;
`ifdef SO_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int WIN = 14;

    logic avr_clk = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    logic [7:0]        mem [256];
    logic [ADDR_W-1:0] ref_addr;

    sram_serial_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_serial_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
        .avr_clk(avr_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 avr_clk = ~avr_clk;

    // SRAM model: low address byte selects a table entry, upper bits are folded in;
    // a junk value is driven whenever output enable is inactive
    assign bus.sram_data = bus.sram_oe_n ? 8'hEE :
        (mem[bus.sram_addr[7:0]] ^ bus.sram_addr[15:8] ^ {3'b000, bus.sram_addr[20:16]});

    function automatic logic [7:0] ram_byte(input logic [ADDR_W-1:0] a);
        return mem[a[7:0]] ^ a[15:8] ^ {3'b000, a[20:16]};
    endfunction

    // Expected per-cycle trace for a read returning byte b; bit c = cycle c after the start edge
    function automatic logic [95:0] exp_trace(input logic [7:0] b);
        logic [8:0]  word;
        logic [15:0] ce, oe, vl, dn, bs, so;
`ifdef SO_PARITY_EN
        word = {b, ^b};
`else
        word = {1'b0, b};
`endif
        ce = '0; oe = '0; vl = '0; dn = '0; bs = '0; so = '0;
        for (int c = 1; c <= WIN; c++) begin
            ce[c] = (c <= WAIT_CYC);
            oe[c] = (c <= WAIT_CYC);
            vl[c] = (c > WAIT_CYC) && (c <= WAIT_CYC + NB);
            dn[c] = (c == WAIT_CYC + NB + 1);
            bs[c] = (c <= WAIT_CYC + NB + 1);
            so[c] = vl[c] ? word[NB - 1 - (c - WAIT_CYC - 1)] : 1'b1;
        end
        return {ce, oe, vl, dn, bs, so};
    endfunction

    task automatic load_addr(input logic [ADDR_W-1:0] a);
        @(negedge avr_clk);
        bus.addr_load = 1'b1;
        bus.addr_in   = a;
        @(negedge avr_clk);
        bus.addr_load = 1'b0;
        ref_addr = a;
    endtask

    // Runs one transaction for a fixed window, optionally loading with the start pulse and
    // injecting rd_start / addr_load(0x55) at given cycles; returns the observed trace
    task automatic xact(input logic ld, input logic [ADDR_W-1:0] ld_val,
                        input int inj_rd, input int inj_ld,
                        output logic [95:0] tr, output logic [2*ADDR_W-1:0] acc);
        logic [15:0] ce, oe, vl, dn, bs, so;
        ce = '0; oe = '0; vl = '0; dn = '0; bs = '0; so = '0; acc = '0;
        @(negedge avr_clk);
        bus.rd_start  = 1'b1;
        bus.addr_load = ld;
        bus.addr_in   = ld_val;
        @(negedge avr_clk);
        bus.rd_start  = 1'b0;
        bus.addr_load = 1'b0;
        for (int c = 1; c <= WIN; c++) begin
            ce[c] = ~bus.sram_ce_n;
            oe[c] = ~bus.sram_oe_n;
            vl[c] = bus.so_valid;
            dn[c] = bus.done;
            bs[c] = bus.busy;
            so[c] = bus.avr_so;
            if (c == 1)        acc[2*ADDR_W-1:ADDR_W] = bus.sram_addr;
            if (c == WAIT_CYC) acc[ADDR_W-1:0]        = bus.sram_addr;
            bus.rd_start  = (c == inj_rd);
            bus.addr_load = (c == inj_ld);
            bus.addr_in   = 21'h00055;
            @(negedge avr_clk);
        end
        bus.rd_start  = 1'b0;
        bus.addr_load = 1'b0;
        tr = {ce, oe, vl, dn, bs, so};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge avr_clk);
        checks++;
        if ({bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.so_valid, bus.busy, bus.done} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=111000",
                     {bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.so_valid, bus.busy, bus.done});
        end
        checks++;
        if (bus.sram_addr !== 21'h0) begin
            errors++;
            $display("FAIL reset_addr got=%h exp=000000", bus.sram_addr);
        end
        reset = 1'b0;
        ref_addr = '0;
    endtask

    task automatic test_basic();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        load_addr(21'h00010);
        et = exp_trace(8'hA5);
        xact(1'b0, '0, 0, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL basic_trace got=%h exp=%h", tr, et); end
        checks++;
        if (acc !== {ref_addr, ref_addr}) begin errors++; $display("FAIL basic_access_addr got=%h exp=%h", acc, {ref_addr, ref_addr}); end
        ref_addr = ref_addr + 1'b1;
        checks++;
        if (bus.sram_addr !== 21'h00011) begin errors++; $display("FAIL basic_addr_after got=%h exp=000011", bus.sram_addr); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        et = exp_trace(8'h3C);
        // rd_start pulsed during DONE must not start another read
        xact(1'b0, '0, WAIT_CYC + NB + 1, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL b2b_trace got=%h exp=%h", tr, et); end
        checks++;
        if (acc !== {ref_addr, ref_addr}) begin errors++; $display("FAIL b2b_access_addr got=%h exp=%h", acc, {ref_addr, ref_addr}); end
        ref_addr = ref_addr + 1'b1;
        checks++;
        if (bus.sram_addr !== 21'h00012) begin errors++; $display("FAIL b2b_addr_after got=%h exp=000012", bus.sram_addr); end
    endtask

    task automatic test_wrap();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        load_addr(21'h1FFFFF);
        et = exp_trace(ram_byte(21'h1FFFFF));
        xact(1'b0, '0, 0, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL wrap_trace got=%h exp=%h", tr, et); end
        ref_addr = '0;
        checks++;
        if (bus.sram_addr !== 21'h0) begin errors++; $display("FAIL wrap_addr_after got=%h exp=000000", bus.sram_addr); end
    endtask

    task automatic test_ignore_mid_shift();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        load_addr(21'h00010);
        et = exp_trace(8'hA5);
        xact(1'b0, '0, WAIT_CYC + 3, WAIT_CYC + 3, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL ignore_trace got=%h exp=%h", tr, et); end
        ref_addr = ref_addr + 1'b1;
        checks++;
        if (bus.sram_addr !== ref_addr) begin errors++; $display("FAIL ignore_addr_after got=%h exp=%h", bus.sram_addr, ref_addr); end
    endtask

    task automatic test_reset_mid_shift();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        load_addr(21'h00033);
        @(negedge avr_clk);
        bus.rd_start = 1'b1;
        @(negedge avr_clk);
        bus.rd_start = 1'b0;
        repeat (WAIT_CYC + 2) @(negedge avr_clk);
        checks++;
        if (bus.so_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_in_shift got=%b exp=1", bus.so_valid); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.busy, bus.so_valid} !== 5'b11100) begin
            errors++;
            $display("FAIL midreset_outputs got=%b exp=11100",
                     {bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.busy, bus.so_valid});
        end
        checks++;
        if (bus.sram_addr !== 21'h0) begin errors++; $display("FAIL midreset_addr got=%h exp=000000", bus.sram_addr); end
        @(negedge avr_clk);
        reset = 1'b0;
        ref_addr = '0;
        et = exp_trace(ram_byte('0));
        xact(1'b0, '0, 0, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL post_reset_trace got=%h exp=%h", tr, et); end
        ref_addr = ref_addr + 1'b1;
        checks++;
        if (bus.sram_addr !== ref_addr) begin errors++; $display("FAIL post_reset_addr got=%h exp=%h", bus.sram_addr, ref_addr); end
    endtask

    task automatic test_parity();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        load_addr(21'h00020);
        et = exp_trace(8'h01);
        xact(1'b0, '0, 0, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL parity_01_trace got=%h exp=%h", tr, et); end
        load_addr(21'h00010);
        et = exp_trace(8'hA5);
        xact(1'b0, '0, 0, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL parity_a5_trace got=%h exp=%h", tr, et); end
        ref_addr = 21'h00011;
    endtask

    task automatic test_load_with_start();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        ref_addr = 21'h00200;
        et = exp_trace(ram_byte(ref_addr));
        xact(1'b1, 21'h00200, 0, 0, tr, acc);
        checks++;
        if (tr !== et) begin errors++; $display("FAIL loadstart_trace got=%h exp=%h", tr, et); end
        checks++;
        if (acc !== {ref_addr, ref_addr}) begin errors++; $display("FAIL loadstart_access_addr got=%h exp=%h", acc, {ref_addr, ref_addr}); end
        ref_addr = ref_addr + 1'b1;
    endtask

    task automatic test_random();
        logic [95:0] tr, et;
        logic [2*ADDR_W-1:0] acc;
        logic [ADDR_W-1:0] a;
        logic ld;
        int mode, ir, il;
        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 3));
            a = ADDR_W'($urandom());
            if ($urandom_range(0, 3) == 0) a = 21'h1FFFFF - ADDR_W'($urandom_range(0, 2));
            ld = 1'b0;
            if (mode == 0) load_addr(a);
            if (mode == 1) begin ld = 1'b1; ref_addr = a; end
            ir = int'($urandom_range(0, WAIT_CYC + NB + 1));
            il = int'($urandom_range(0, WAIT_CYC + NB + 1));
            et = exp_trace(ram_byte(ref_addr));
            xact(ld, a, ir, il, tr, acc);
            checks++;
            if (tr !== et) begin errors++; $display("FAIL rand%0d_trace got=%h exp=%h", n, tr, et); end
            checks++;
            if (acc !== {ref_addr, ref_addr}) begin errors++; $display("FAIL rand%0d_access_addr got=%h exp=%h", n, acc, {ref_addr, ref_addr}); end
            ref_addr = ref_addr + 1'b1;
            checks++;
            if (bus.sram_addr !== ref_addr) begin errors++; $display("FAIL rand%0d_addr_after got=%h exp=%h", n, bus.sram_addr, ref_addr); end
        end
    endtask

    initial begin
        bus.addr_load = 1'b0;
        bus.addr_in   = '0;
        bus.rd_start  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h3C;
        mem[8'h20] = 8'h01;
        ref_addr = '0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_ignore_mid_shift();
        test_reset_mid_shift();
        test_parity();
        test_load_with_start();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
